// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with saturating counters, EX-side training and perf counters
module branch_target_predictor #(
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pred_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_is_jump,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] correct_pc,
    output logic [31:0] cnt_lookups,
    output logic [31:0] cnt_mispredicts
);
    localparam int IB = $clog2(ENTRIES);
    localparam int TW = 30 - IB;
    localparam logic [CTR_BITS-1:0] CMAX  = '1;
    localparam logic [CTR_BITS-1:0] CONE  = CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CWEAK = CONE << (CTR_BITS - 1);

    logic                valid_q [ENTRIES];
    logic                jump_q  [ENTRIES];
    logic [TW-1:0]       tag_q   [ENTRIES];
    logic [31:0]         tgt_q   [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q   [ENTRIES];
    logic [IB-1:0]       pidx, uidx;
    logic [TW-1:0]       ptag, utag;
    logic                phit, uhit, wr;
    logic [CTR_BITS-1:0] ctr_d;
    logic [31:0]         cnt_lookups_q, cnt_lookups_d, cnt_mis_q, cnt_mis_d;

    // IF-side lookup: reads pre-update contents, no bypass from the training write
    always_comb begin
        pidx        = pred_pc[IB+1:2];
        ptag        = pred_pc[31:IB+2];
        phit        = valid_q[pidx] && tag_q[pidx] == ptag;
        pred_taken  = phit && (jump_q[pidx] || ctr_q[pidx][CTR_BITS-1]);
        pred_target = pred_taken ? tgt_q[pidx] : pred_pc + 32'd4;
    end

    // EX-side resolution and next-state of the indexed entry's counter
    always_comb begin
        uidx          = upd_pc[IB+1:2];
        utag          = upd_pc[31:IB+2];
        uhit          = valid_q[uidx] && tag_q[uidx] == utag;
        wr            = upd_valid && (uhit || upd_taken);
        ctr_d         = (upd_is_jump || !uhit) ? (upd_is_jump ? CMAX : CWEAK)
                      : upd_taken ? (ctr_q[uidx] == CMAX ? CMAX : ctr_q[uidx] + CONE)
                      : (ctr_q[uidx] == '0 ? '0 : ctr_q[uidx] - CONE);
        mispredict    = upd_valid && (upd_taken != upd_pred_taken ||
                        (upd_taken && upd_target != upd_pred_target));
        correct_pc    = upd_taken ? upd_target : upd_pc + 32'd4;
        cnt_lookups_d = upd_valid ? cnt_lookups_q + 32'd1 : cnt_lookups_q;
        cnt_mis_d     = cnt_mis_q + {31'd0, mispredict};
    end

    // Table training: a hit trains in place, a taken miss allocates over the index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                jump_q[i]  <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= '0;
            end
        end else if (wr) begin
            valid_q[uidx] <= 1'b1;
            jump_q[uidx]  <= uhit ? (jump_q[uidx] || upd_is_jump) : upd_is_jump;
            tag_q[uidx]   <= utag;
            ctr_q[uidx]   <= ctr_d;
            if (upd_taken) tgt_q[uidx] <= upd_target;
        end
    end

    // Performance counters, wrapping modulo 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_lookups_q <= '0;
            cnt_mis_q     <= '0;
        end else begin
            cnt_lookups_q <= cnt_lookups_d;
            cnt_mis_q     <= cnt_mis_d;
        end
    end

    assign cnt_lookups     = cnt_lookups_q;
    assign cnt_mispredicts = cnt_mis_q;
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: directed and randomized checks against a behavioural BTB model
module tb_branch_target_predictor;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] pred_pc = '0, upd_pc = '0, upd_target = '0, upd_pred_target = '0;
    logic        upd_valid = 1'b0, upd_is_jump = 1'b0, upd_taken = 1'b0, upd_pred_taken = 1'b0;
    logic        pred_taken, mispredict;
    logic [31:0] pred_target, correct_pc, cnt_lookups, cnt_mispredicts;
    int total = 0, bad = 0;

    bit          mv [64];
    bit          mj [64];
    logic [31:0] mtag [64];
    logic [31:0] mtgt [64];
    int          mc [64];
    int unsigned ml, mm;

    always #5 clk = ~clk;

    branch_target_predictor #(.ENTRIES(64), .CTR_BITS(2)) dut (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .correct_pc(correct_pc), .cnt_lookups(cnt_lookups),
        .cnt_mispredicts(cnt_mispredicts)
    );

    function automatic int ix(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return mv[ix(pc)] && mtag[ix(pc)] == (pc >> 8);
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (mj[ix(pc)] || mc[ix(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc);
        return m_taken(pc) ? mtgt[ix(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mis();
        return upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) begin
            mv[i] = 0; mj[i] = 0; mtag[i] = 0; mtgt[i] = 0; mc[i] = 0;
        end
        ml = 0; mm = 0;
    endtask

    task automatic m_train();
        int i;
        if (!upd_valid) return;
        i = ix(upd_pc);
        ml++;
        mm += m_mis() ? 1 : 0;
        if (m_hit(upd_pc)) begin
            if (upd_is_jump) begin
                mj[i] = 1; mtgt[i] = upd_target; mc[i] = 3;
            end else begin
                mc[i] = upd_taken ? (mc[i] == 3 ? 3 : mc[i] + 1) : (mc[i] == 0 ? 0 : mc[i] - 1);
                if (upd_taken) mtgt[i] = upd_target;
            end
        end else if (upd_taken) begin
            mv[i] = 1; mj[i] = upd_is_jump; mtag[i] = upd_pc >> 8; mtgt[i] = upd_target;
            mc[i] = upd_is_jump ? 3 : 2;
        end
    endtask

    task automatic drive(input logic [31:0] pc, input bit j, input bit t, input logic [31:0] tgt,
                         input bit pt, input logic [31:0] ptg);
        upd_valid = 1; upd_pc = pc; upd_is_jump = j; upd_taken = t; upd_target = tgt;
        upd_pred_taken = pt; upd_pred_target = ptg;
    endtask

    task automatic step();
        @(posedge clk);
        m_train();
        @(negedge clk);
        upd_valid = 0;
    endtask

    task automatic look(input logic [31:0] pc);
        pred_pc = pc;
        #1;
    endtask

    task automatic test_reset();
        m_reset();
        rst = 1; pred_pc = 32'h60;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%0b exp=0", pred_taken); end
        total++; if (pred_target !== 32'h64) begin bad++; $display("FAIL reset_target got=%h exp=00000064", pred_target); end
        total++; if (cnt_lookups !== 32'd0) begin bad++; $display("FAIL reset_lookups got=%0d exp=0", cnt_lookups); end
        total++; if (cnt_mispredicts !== 32'd0) begin bad++; $display("FAIL reset_mis got=%0d exp=0", cnt_mispredicts); end
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL reset_mispredict got=%0b exp=0", mispredict); end
    endtask

    task automatic test_first_taken();
        drive(32'h100, 0, 1, 32'h80, 0, 32'h104);
        #1;
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL first_mis got=%0b exp=1", mispredict); end
        total++; if (correct_pc !== 32'h80) begin bad++; $display("FAIL first_correct got=%h exp=00000080", correct_pc); end
        step();
        look(32'h100);
        total++; if (cnt_mispredicts !== 32'd1) begin bad++; $display("FAIL first_cntmis got=%0d exp=1", cnt_mispredicts); end
        total++; if (cnt_lookups !== 32'd1) begin bad++; $display("FAIL first_cntlk got=%0d exp=1", cnt_lookups); end
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL first_taken got=%0b exp=1", pred_taken); end
        total++; if (pred_target !== 32'h80) begin bad++; $display("FAIL first_target got=%h exp=00000080", pred_target); end
    endtask

    task automatic test_counter();
        drive(32'h100, 0, 0, 32'h0, 1, 32'h80);
        #1;
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL ctr_mis got=%0b exp=1", mispredict); end
        total++; if (correct_pc !== 32'h104) begin bad++; $display("FAIL ctr_correct got=%h exp=00000104", correct_pc); end
        step();
        look(32'h100);
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL ctr1_taken got=%0b exp=0", pred_taken); end
        total++; if (pred_target !== 32'h104) begin bad++; $display("FAIL ctr1_target got=%h exp=00000104", pred_target); end
        repeat (4) begin drive(32'h100, 0, 0, 32'h0, 0, 32'h104); step(); end
        drive(32'h100, 0, 1, 32'h80, 0, 32'h104); step();
        look(32'h100);
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL ctr_sat0 got=%0b exp=0", pred_taken); end
        repeat (4) begin drive(32'h100, 0, 1, 32'h80, 0, 32'h104); step(); end
        drive(32'h100, 0, 0, 32'h0, 1, 32'h80); step();
        look(32'h100);
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL ctr_sat3 got=%0b exp=1", pred_taken); end
        drive(32'h300, 0, 0, 32'h0, 0, 32'h304); step();
        look(32'h300);
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL noalloc_taken got=%0b exp=0", pred_taken); end
        look(32'h100);
        total++; if (pred_target !== 32'h80) begin bad++; $display("FAIL noalloc_keep got=%h exp=00000080", pred_target); end
    endtask

    task automatic test_alias();
        look(32'h200);
        total++; if (pred_target !== 32'h204) begin bad++; $display("FAIL alias_miss got=%h exp=00000204", pred_target); end
        drive(32'h200, 0, 1, 32'h40, 0, 32'h204); step();
        look(32'h100);
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL alias_evict got=%0b exp=0", pred_taken); end
        look(32'h200);
        total++; if (pred_target !== 32'h40) begin bad++; $display("FAIL alias_new got=%h exp=00000040", pred_target); end
    endtask

    task automatic test_jump();
        drive(32'h40, 1, 1, 32'h400, 0, 32'h44); step();
        look(32'h40);
        total++; if (pred_taken !== 1'b1 || pred_target !== 32'h400) begin bad++; $display("FAIL jal_pred got=%0b/%h exp=1/00000400", pred_taken, pred_target); end
        drive(32'h40, 1, 1, 32'h500, 1, 32'h400);
        #1;
        total++; if (mispredict !== 1'b1 || correct_pc !== 32'h500) begin bad++; $display("FAIL jalr_mis got=%0b/%h exp=1/00000500", mispredict, correct_pc); end
        step();
        look(32'h40);
        total++; if (pred_target !== 32'h500) begin bad++; $display("FAIL jalr_retrain got=%h exp=00000500", pred_target); end
        drive(32'h40, 1, 1, 32'h500, 1, 32'h500);
        #1;
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL jump_hit got=%0b exp=0", mispredict); end
        step();
        drive(32'h300, 0, 0, 32'h0, 0, 32'h999);
        #1;
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL nt_target_ignored got=%0b exp=0", mispredict); end
        step();
    endtask

    task automatic test_collision();
        pred_pc = 32'h200;
        drive(32'h200, 0, 1, 32'h88, 1, 32'h40);
        #1;
        total++; if (pred_target !== 32'h40) begin bad++; $display("FAIL coll_old got=%h exp=00000040", pred_target); end
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL coll_mis got=%0b exp=1", mispredict); end
        step();
        look(32'h200);
        total++; if (pred_target !== 32'h88) begin bad++; $display("FAIL coll_new got=%h exp=00000088", pred_target); end
    endtask

    task automatic test_async_reset();
        pred_pc = 32'h40;
        drive(32'h700, 0, 1, 32'h123, 0, 32'h704);
        #2 rst = 1;
        #1;
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL arst_clear got=%0b exp=0", pred_taken); end
        total++; if (cnt_lookups !== 32'd0) begin bad++; $display("FAIL arst_cnt got=%0d exp=0", cnt_lookups); end
        @(posedge clk);
        @(negedge clk);
        upd_valid = 0; rst = 0;
        m_reset();
        look(32'h700);
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL arst_dropped got=%0b exp=0", pred_taken); end
        look(32'h200);
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL arst_invalid got=%0b exp=0", pred_taken); end
        total++; if (cnt_lookups !== 32'd0 || cnt_mispredicts !== 32'd0) begin bad++; $display("FAIL arst_counters got=%0d/%0d exp=0/0", cnt_lookups, cnt_mispredicts); end
    endtask

    task automatic test_random();
        logic [31:0] pc, tgt;
        bit j, t;
        for (int n = 0; n < 400; n++) begin
            pc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
            tgt = $urandom & 32'hFFFF_FFFC;
            j   = ($urandom_range(0, 3) == 0);
            t   = j ? 1'b1 : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) drive(pc, j, t, tgt, m_taken(pc), m_target(pc));
            else drive(pc, j, t, tgt, 1'($urandom_range(0, 1)), (j || $urandom_range(0, 1) == 0) ? tgt : pc + 32'd4);
            upd_valid = ($urandom_range(0, 3) != 0);
            pred_pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
            #1;
            total++; if (pred_taken !== m_taken(pred_pc) || pred_target !== m_target(pred_pc)) begin
                bad++; $display("FAIL rnd_pred pc=%h got=%0b/%h exp=%0b/%h", pred_pc, pred_taken, pred_target, m_taken(pred_pc), m_target(pred_pc)); end
            total++; if (mispredict !== m_mis() || correct_pc !== (t ? tgt : pc + 32'd4)) begin
                bad++; $display("FAIL rnd_resolve got=%0b/%h exp=%0b/%h", mispredict, correct_pc, m_mis(), t ? tgt : pc + 32'd4); end
            total++; if (cnt_lookups !== ml || cnt_mispredicts !== mm) begin
                bad++; $display("FAIL rnd_counters got=%0d/%0d exp=%0d/%0d", cnt_lookups, cnt_mispredicts, ml, mm); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_first_taken();
        test_counter();
        test_alias();
        test_jump();
        test_collision();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
